// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the write-port arbiter and its producers / FIFO.
// master = arbiter side, slave = producers and FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [CNT_W-1:0]          fifo_counter;
  logic                      fifo_full;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_buf_in;
  logic [2:0]                grant_id;
  logic                      busy;
  logic                      stall;

  modport master (
    input  req_valid, req_data, fifo_counter, fifo_full,
    output req_ready, fifo_wr_en, fifo_buf_in, grant_id, busy, stall
  );

  modport slave (
    output req_valid, req_data, fifo_counter, fifo_full,
    input  req_ready, fifo_wr_en, fifo_buf_in, grant_id, busy, stall
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// granting bursts of up to BURST_MAX words and never overflowing the FIFO.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  fifo_wr_arbiter_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e              state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [2:0]          rr_q, rr_d;
  logic [3:0]          burst_q, burst_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   buf_q, buf_d;

  logic [2:0]          winner;
  logic                found;
  logic                owner_valid;
  logic [DATA_W-1:0]   owner_data;
  logic [NUM_REQ-1:0]  ready;
  logic [CNT_W:0]      occ;
  logic                space_ok;
  logic                xfer;

  // The registered write still in flight counts against the free space.
  assign occ      = {1'b0, bus.fifo_counter} + {{CNT_W{1'b0}}, wr_en_q};
  assign space_ok = !bus.fifo_full && (occ < (CNT_W+1)'(DEPTH));

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // First valid requester after rr_q, wrapping modulo NUM_REQ.
  always_comb begin : pick
    int unsigned idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(rr_q) + k) % NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && (idx == j) && bus.req_valid[j]) begin
          found  = 1'b1;
          winner = 3'(j);
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if ((state_q == GRANT) && (grant_q == 3'(i))) ready[i] = space_ok;
    end
  end

  assign xfer = (state_q == GRANT) && owner_valid && space_ok;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    wr_en_d = 1'b0;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          wr_en_d = 1'b1;
          buf_d   = owner_data;
          burst_d = burst_q + 4'd1;
          if (burst_q == 4'(BURST_MAX - 1)) begin
            state_d = IDLE;
            rr_d    = grant_q;
          end
        end else if (!owner_valid) begin
          state_d = IDLE;
          rr_d    = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= 3'(NUM_REQ - 1);
      burst_q <= '0;
      wr_en_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      wr_en_q <= wr_en_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.fifo_wr_en  = wr_en_q;
  assign bus.fifo_buf_in = buf_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = (state_q == GRANT);
  assign bus.stall       = (state_q == GRANT) && owner_valid && !space_ok;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues, a FIFO fed by the DUT outputs and
// a transaction-level arbitration model, with directed scenarios then random traffic.
module tb_fifo_wr_arbiter;
  localparam int unsigned NR    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned CW    = 8;
  localparam int unsigned BM    = 4;

  logic clk;
  logic rst;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .CNT_W(CW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .BURST_MAX(BM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] pq [NR][$];
  bit         en [NR];
  logic [7:0] fq [$];
  bit         rd;
  bit         ovf;

  bit         m_busy;
  int         m_owner, m_cnt, m_last;
  bit         m_pend;
  logic [7:0] m_data;

  int dlog [$];
  int dlen [$];
  int dcyc [$];
  bit pbusy;
  int cyc;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in();
    for (int unsigned i = 0; i < NR; i++) begin
      bus.req_valid[i]          = en[i] && (pq[i].size() > 0);
      bus.req_data[i*DW +: DW]  = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
    end
    bus.fifo_counter = CW'(fq.size());
    bus.fifo_full    = (fq.size() == DEPTH);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_last = NR - 1;
    m_pend = 1'b0; m_data = 8'h00; pbusy = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 32'd0);
    chk({tag, "_buf"},   32'(bus.fifo_buf_in), 32'd0);
    chk({tag, "_gid"},   32'(bus.grant_id), 32'd0);
    chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    drive_in();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk_zero("rst");
    end
    rst = 1'b0;
  endtask

  // One clock: check outputs against the model, advance model and FIFO.
  task automatic tick();
    bit space, ov, xfer, fnd, wr, rd_ok;
    logic [NR-1:0] er;
    logic [7:0] wd;
    #1;
    space = (fq.size() + (m_pend ? 1 : 0)) < DEPTH;
    ov    = m_busy && bus.req_valid[m_owner];
    er    = '0;
    if (m_busy && space) er[m_owner] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    if (m_busy) chk("grant_id", 32'(bus.grant_id), 32'(m_owner));
    chk("stall", 32'(bus.stall), 32'(ov && !space));
    chk("wr_en", 32'(bus.fifo_wr_en), 32'(m_pend));
    chk("buf_in", 32'(bus.fifo_buf_in), 32'(m_data));

    if (bus.busy && !pbusy) begin
      dlog.push_back(int'(bus.grant_id)); dlen.push_back(0); dcyc.push_back(cyc);
    end
    if (bus.busy && ((bus.req_ready & bus.req_valid) != '0) && dlen.size() > 0)
      dlen[dlen.size()-1] = dlen[dlen.size()-1] + 1;
    pbusy = bus.busy;

    xfer = ov && space;
    if (m_busy) begin
      if (xfer) begin
        m_data = pq[m_owner].pop_front();
        m_cnt++;
        if (m_cnt == BM) begin m_busy = 1'b0; m_last = m_owner; end
      end else if (!ov) begin
        m_busy = 1'b0; m_last = m_owner;
      end
    end else if (bus.req_valid != '0) begin
      fnd = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (m_last + k) % NR;
        if (!fnd && bus.req_valid[idx]) begin fnd = 1'b1; m_owner = idx; end
      end
      m_busy = 1'b1; m_cnt = 0;
    end

    wr    = bus.fifo_wr_en;
    wd    = bus.fifo_buf_in;
    rd_ok = rd && (fq.size() > 0);
    if (wr && fq.size() >= DEPTH) ovf = 1'b1;
    if (rd_ok) void'(fq.pop_front());
    if (wr && !ovf) fq.push_back(wd);
    m_pend = xfer;

    @(posedge clk); #1;
    cyc++;
    drive_in();
  endtask

  function automatic bit pending();
    bit p;
    p = m_busy || m_pend;
    for (int unsigned i = 0; i < NR; i++) if (en[i] && pq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_until_idle(input string tag, input int maxc);
    int n;
    n = 0;
    while (pending() && n < maxc) begin tick(); n++; end
    chk({tag, "_done"}, 32'(n < maxc), 32'd1);
  endtask

  task automatic drain_fifo();
    int n;
    n = 0;
    rd = 1'b1;
    while (fq.size() > 0 && n < 200) begin tick(); n++; end
    rd = 1'b0;
    chk("drain_done", 32'(fq.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    checks = 0; errors = 0; cyc = 0; rd = 1'b0; ovf = 1'b0;
    rst = 1'b1;
    model_reset();

    // 1: reset with all requesters valid; requester 0 wins first
    for (int unsigned i = 0; i < NR; i++) begin en[i] = 1'b1; pq[i].push_back(8'(8'hA0 + i)); end
    drive_in();
    do_reset(2);
    tick();
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_first_gid", 32'(bus.grant_id), 32'd0);
    run_until_idle("t1", 200);
    drain_fifo();

    // 2: requester 2 alone, ten words -> bursts 4,4,2
    for (int unsigned i = 0; i < NR; i++) en[i] = 1'b0;
    for (int k = 1; k <= 10; k++) pq[2].push_back(8'(k));
    en[2] = 1'b1;
    drive_in();
    s = dlog.size();
    run_until_idle("t2", 200);
    chk("t2_ngrants", 32'(dlog.size() - s), 32'd3);
    for (int g = 0; g < 3; g++) begin
      chk("t2_gid", 32'(dlog[s+g]), 32'd2);
      chk("t2_len", 32'(dlen[s+g]), (g == 2) ? 32'd2 : 32'd4);
    end
    chk("t2_count", 32'(bus.fifo_counter), 32'd10);
    for (int k = 0; k < 10; k++) chk("t2_data", 32'(fq[k]), 32'(k + 1));
    en[2] = 1'b0;
    drain_fifo();

    // 3: all four valid, 8 words each -> order 0,1,2,3,0,1,2,3
    do_reset(1);
    for (int unsigned i = 0; i < NR; i++) begin
      for (int k = 0; k < 8; k++) pq[i].push_back(8'(8'h10 + i*8'h10 + k));
      en[i] = 1'b1;
    end
    drive_in();
    s = dlog.size();
    run_until_idle("t3", 400);
    chk("t3_ngrants", 32'(dlog.size() - s), 32'd8);
    chk("t3_words", 32'(fq.size()), 32'd32);
    for (int g = 0; g < 8; g++) begin
      chk("t3_gid", 32'(dlog[s+g]), 32'(g % 4));
      chk("t3_len", 32'(dlen[s+g]), 32'd4);
      for (int w = 0; w < 4; w++)
        chk("t3_data", 32'(fq[g*4+w]), 32'(8'h10 + (g % 4)*8'h10 + (g / 4)*4 + w));
    end
    for (int unsigned i = 0; i < NR; i++) en[i] = 1'b0;
    drain_fifo();

    // 4: FIFO preloaded to 62, requester 1 streams 5 words
    for (int k = 0; k < 62; k++) fq.push_back(8'hEE);
    for (int k = 0; k < 5; k++) pq[1].push_back(8'(8'h41 + k));
    en[1] = 1'b1;
    drive_in();
    for (int k = 0; k < 12; k++) tick();
    chk("t4_fifo_size", 32'(fq.size()), 32'd64);
    chk("t4_left", 32'(pq[1].size()), 32'd3);
    chk("t4_stall", 32'(bus.stall), 32'd1);
    chk("t4_ready", 32'(bus.req_ready), 32'd0);
    chk("t4_ovf", 32'(ovf), 32'd0);
    rd = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    rd = 1'b0;
    run_until_idle("t4", 100);
    chk("t4_final_size", 32'(fq.size()), 32'd64);
    for (int k = 0; k < 5; k++) chk("t4_data", 32'(fq[59+k]), 32'(8'h41 + k));
    chk("t4_ovf_end", 32'(ovf), 32'd0);
    en[1] = 1'b0;
    drain_fifo();

    // 5: requester 3 sends two words and releases while 0 waits
    pq[3].push_back(8'h31); pq[3].push_back(8'h32);
    pq[0].push_back(8'h01); pq[0].push_back(8'h02);
    en[3] = 1'b1;
    drive_in();
    s = dlog.size();
    tick();
    en[0] = 1'b1;
    drive_in();
    run_until_idle("t5", 100);
    chk("t5_gid_a", 32'(dlog[s]), 32'd3);
    chk("t5_len_a", 32'(dlen[s]), 32'd2);
    chk("t5_gid_b", 32'(dlog[s+1]), 32'd0);
    chk("t5_gap", 32'(dcyc[s+1] - dcyc[s]), 32'd4);
    en[0] = 1'b0; en[3] = 1'b0;
    drain_fifo();

    // 6: reset right after the second transfer of a burst
    for (int k = 0; k < 4; k++) pq[2].push_back(8'(8'h61 + k));
    pq[0].push_back(8'h71);
    en[2] = 1'b1;
    drive_in();
    s = dlog.size();
    n = 0;
    while (!(dlog.size() > s && dlen[dlen.size()-1] == 2) && n < 20) begin tick(); n++; end
    chk("t6_reached", 32'(n < 20), 32'd1);
    chk("t6_inflight", 32'(bus.fifo_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_wr_dropped", 32'(bus.fifo_wr_en), 32'd0);
    chk("t6_busy_dropped", 32'(bus.busy), 32'd0);
    en[0] = 1'b1;
    do_reset(1);
    tick();
    chk("t6_regrant", 32'(bus.grant_id), 32'd0);
    chk("t6_regrant_busy", 32'(bus.busy), 32'd1);
    run_until_idle("t6", 100);
    chk("t6_words", 32'(fq.size()), 32'd4);
    en[0] = 1'b0; en[2] = 1'b0;
    drain_fifo();

    // Random traffic, random reads, random valid toggling
    for (int c = 0; c < 2500; c++) begin
      int r;
      r = $urandom_range(0, NR - 1);
      if ($urandom_range(0, 3) == 0) en[r] = !en[r];
      if ($urandom_range(0, 1) == 1 && pq[r].size() < 12) pq[r].push_back(8'($urandom));
      rd = ($urandom_range(0, 3) == 0);
      drive_in();
      tick();
    end
    rd = 1'b1;
    for (int unsigned i = 0; i < NR; i++) en[i] = 1'b1;
    drive_in();
    run_until_idle("rand", 3000);
    chk("rand_ovf", 32'(ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that lets NUM_REQ producers share the write port of the single-clock 8-bit FIFO (fifo_new_singleclk).
- Grants one requester at a time for bursts of up to BURST_MAX words.
- Drives fifo wr_en/buf_in from registers.
- Uses the FIFO's fifo_counter for credit so that the FIFO never overflows.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: data width; matches FIFO buf_in.
- DEPTH, 64: FIFO depth in words.
- CNT_W, 8: width of fifo_counter.
- BURST_MAX, 4: maximum words per grant (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester valid.
- req_data  in  NUM_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester ready; combinational, one-hot or zero.
- fifo_counter  in  CNT_W  occupancy from the FIFO.
- fifo_full  in  1  buf_full from the FIFO.
- fifo_wr_en  out  1  registered write enable to the FIFO.
- fifo_buf_in  out  DATA_W  registered write data to the FIFO.
- grant_id  out  3  index of the current owner; valid while busy.
- busy  out  1  high in the GRANT state.
- stall  out  1  high when in GRANT, the owner is valid, and there is no space.

Behaviour:

Reset (asynchronous, any cycle):
- State = IDLE.
- fifo_wr_en = 0, fifo_buf_in = 0, grant_id = 0, busy = 0, stall = 0, req_ready = 0.
- burst_cnt = 0; rr_ptr = NUM_REQ-1, so requester 0 wins first.
- A reset mid-burst drops the in-flight word: no write is issued after rst rises.

Credit:
- space_ok = !fifo_full && (fifo_counter + fifo_wr_en) < DEPTH.
- Compute the sum at CNT_W+1 bits.
- fifo_wr_en is counted because a registered write is already in flight.
- Credit is conservative: reads in the same cycle are ignored.

IDLE state:
- If any req_valid is high, select the first valid index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
- On the next edge: grant_id <= winner, burst_cnt <= 0, state <= GRANT.
- No transfer happens in IDLE.

GRANT state:
- req_ready[grant_id] = space_ok. All other ready bits are 0.
- A transfer occurs when req_valid[grant_id] && req_ready[grant_id].
- On a transfer edge: fifo_wr_en <= 1, fifo_buf_in <= that requester's data, burst_cnt++.
- With no transfer: fifo_wr_en <= 0, and fifo_buf_in holds its value.
- Exit to IDLE, with rr_ptr <= grant_id, when either:
  - a transfer occurs with burst_cnt == BURST_MAX-1, or
  - req_valid[grant_id] is low (with no transfer this cycle).
- When !space_ok and the owner is valid, the arbiter stays in GRANT with stall = 1. There is no timeout.

Latency:
- Requester valid in IDLE → grant on the next edge → first word accepted in the following cycle → fifo_wr_en high one cycle after acceptance.
- A requester holding valid gets back-to-back transfers with no gaps while space_ok holds.
- Between grants there is one IDLE bubble cycle.

Fairness:
- A requester that has just been served has the lowest priority at the next arbitration.
- With all NUM_REQ requesters valid, the grant order is 0,1,2,3,0,...

Simultaneous events:
- Valid changes on non-owners during GRANT are ignored.
- An owner dropping valid on the same edge as a final-burst transfer takes the single exit path: rr_ptr is updated once.
- The arbiter never asserts fifo_wr_en when the FIFO would overflow, so fifo_overflow never rises.

Test Plan:
1. Reset: hold rst=1 for 2 cycles while req_valid=4'b1111 → all outputs 0, no fifo_wr_en. After release, the first grant_id is 0.
2. Single requester: requester 2 streams 10 words 0x01..0x0A with valid held, empty FIFO → three grants of 4,4,2 words to id 2, separated by one IDLE cycle each. The FIFO receives 0x01..0x0A in order and fifo_counter ends at 10.
3. Fairness: all four requesters valid with distinct data (0x10+i*0x10 incrementing), 8 words each → grant sequence 0,1,2,3,0,1,2,3, 4 words per grant, 32 words written in correct per-requester order.
4. Full/credit: preload the FIFO to 62 with no reads, then requester 1 streams 5 words → exactly 2 writes, then stall=1 and req_ready=0. fifo_full rises and fifo_overflow stays 0. Reading 3 words resumes the transfer with no loss or duplication.
5. Early release: requester 3 sends 2 words and then drops valid while requester 0 is waiting → a 2-word grant to 3, an IDLE bubble, then requester 0 is granted.
6. Reset mid-burst: assert rst on the cycle after the 2nd transfer of a burst → fifo_wr_en is 0 immediately. After release, arbitration restarts with requester 0 having priority.
